// File: rtl/fir_stream_filter.sv
// Time-multiplexed FIR: one multiplier, serial MAC over TAPS cycles, AXI-stream in/out, loadable coefficients.
// Optional FIR_OUT_SAT_EN: saturate instead of wrap when OUT_W is narrower than the accumulator.
module fir_stream_filter #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int TAPS   = 8,
   parameter int OUT_W  = 40
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic                     s_axis_data_tvalid,
   output logic                     s_axis_data_tready,
   input  logic signed [DATA_W-1:0] s_axis_data_tdata,
   output logic                     m_axis_data_tvalid,
   input  logic                     m_axis_data_tready,
   output logic signed [OUT_W-1:0]  m_axis_data_tdata,
   input  logic                     coef_wr_en,
   input  logic [$clog2(TAPS)-1:0]  coef_wr_addr,
   input  logic signed [COEF_W-1:0] coef_wr_data,
   output logic                     coef_wr_ready
);
   localparam int AW     = $clog2(TAPS);
   localparam int PROD_W = DATA_W + COEF_W;
   localparam int ACC_W  = PROD_W + AW;

   typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;

   state_t                   state_q, state_d;
   logic signed [DATA_W-1:0] x_q    [TAPS];
   logic signed [DATA_W-1:0] x_d    [TAPS];
   logic signed [COEF_W-1:0] coef_q [TAPS];
   logic signed [COEF_W-1:0] coef_d [TAPS];
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [AW-1:0]            tapIdx_q, tapIdx_d;
   logic signed [OUT_W-1:0]  outData_q, outData_d;

   logic signed [PROD_W-1:0] product;
   logic signed [ACC_W-1:0]  accSum;
   logic signed [OUT_W-1:0]  accFit;
   logic                     lastTap;
   logic                     addrInRange;
   logic                     inIdle;

   assign product = PROD_W'(x_q[tapIdx_q]) * PROD_W'(coef_q[tapIdx_q]);
   assign accSum  = acc_q + ACC_W'(product);
   assign lastTap = (tapIdx_q == AW'(TAPS - 1));

   assign inIdle             = (state_q == IDLE) && !areset;
   assign s_axis_data_tready = inIdle;
   assign coef_wr_ready      = inIdle;
   assign m_axis_data_tvalid = (state_q == HOLD);
   assign m_axis_data_tdata  = outData_q;

   // Addresses only need a range check when TAPS leaves unused codes in the address field.
   generate
      if (TAPS == (1 << AW)) begin : gAddrFull
         assign addrInRange = 1'b1;
      end else begin : gAddrPart
         assign addrInRange = (coef_wr_addr < AW'(TAPS));
      end

      if (OUT_W >= ACC_W) begin : gOutExt
         assign accFit = OUT_W'(accSum);
      end else begin : gOutNarrow
`ifdef FIR_OUT_SAT_EN
         logic [ACC_W-OUT_W:0] headBits;
         assign headBits = accSum[ACC_W-1:OUT_W-1];
         always_comb begin
            accFit = accSum[OUT_W-1:0];
            if (!((&headBits) || !(|headBits))) begin
               accFit = accSum[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
            end
         end
`else
         assign accFit = OUT_W'(accSum);
`endif
      end
   endgenerate

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      coef_d    = coef_q;
      acc_d     = acc_q;
      tapIdx_d  = tapIdx_q;
      outData_d = outData_q;
      case (state_q)
         IDLE: begin
            if (s_axis_data_tvalid) begin
               x_d[0] = s_axis_data_tdata;
               for (int k = 1; k < TAPS; k++) begin
                  x_d[k] = x_q[k-1];
               end
               acc_d    = '0;
               tapIdx_d = '0;
               state_d  = MAC;
            end
         end
         MAC: begin
            acc_d    = accSum;
            tapIdx_d = tapIdx_q + AW'(1);
            if (lastTap) begin
               outData_d = accFit;
               state_d   = HOLD;
            end
         end
         HOLD: begin
            if (m_axis_data_tready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // A write in the accept cycle lands before the first MAC cycle, so that sample sees it.
      if (coef_wr_en && inIdle && addrInRange) begin
         coef_d[coef_wr_addr] = coef_wr_data;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         tapIdx_q  <= '0;
         outData_q <= '0;
         for (int k = 0; k < TAPS; k++) begin
            x_q[k]    <= '0;
            coef_q[k] <= '0;
         end
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         coef_q    <= coef_d;
         acc_q     <= acc_d;
         tapIdx_q  <= tapIdx_d;
         outData_q <= outData_d;
      end
   end

endmodule

// File: tb/tb_fir_stream_filter.sv
// Self-checking bench for fir_stream_filter: a 40-bit and a 32-bit output instance share stimulus,
// checked against a sum-of-products reference model (honours FIR_OUT_SAT_EN).
module tb_fir_stream_filter;
   localparam int TAPS = 8;
   localparam longint NMAX = (64'sd1 <<< 31) - 64'sd1;
   localparam longint NMIN = -(64'sd1 <<< 31);

   logic        aclk = 1'b0;
   logic        areset;
   logic        sTvalid, mTready, coefWrEn;
   logic [15:0] sTdata, coefWrData;
   logic [2:0]  coefWrAddr;
   logic        sTready, mTvalid, coefWrReady;
   logic        sTreadyN, mTvalidN, coefWrReadyN;
   logic [39:0] mTdata;
   logic [31:0] mTdataN;

   always #5 aclk = ~aclk;

   fir_stream_filter #(.DATA_W(16), .COEF_W(16), .TAPS(TAPS), .OUT_W(40)) dut (
      .aclk(aclk), .areset(areset),
      .s_axis_data_tvalid(sTvalid), .s_axis_data_tready(sTready), .s_axis_data_tdata(sTdata),
      .m_axis_data_tvalid(mTvalid), .m_axis_data_tready(mTready), .m_axis_data_tdata(mTdata),
      .coef_wr_en(coefWrEn), .coef_wr_addr(coefWrAddr), .coef_wr_data(coefWrData),
      .coef_wr_ready(coefWrReady)
   );

   fir_stream_filter #(.DATA_W(16), .COEF_W(16), .TAPS(TAPS), .OUT_W(32)) dutNarrow (
      .aclk(aclk), .areset(areset),
      .s_axis_data_tvalid(sTvalid), .s_axis_data_tready(sTreadyN), .s_axis_data_tdata(sTdata),
      .m_axis_data_tvalid(mTvalidN), .m_axis_data_tready(mTready), .m_axis_data_tdata(mTdataN),
      .coef_wr_en(coefWrEn), .coef_wr_addr(coefWrAddr), .coef_wr_data(coefWrData),
      .coef_wr_ready(coefWrReadyN)
   );

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          acceptCyc = 0, prevAcceptCyc = 0, handshakeCyc = 0;
   longint      coefModel [TAPS];
   longint      histModel [TAPS];
   logic [39:0] expWide, lastOut;
   logic [31:0] expNarrow, lastOutN;
   int          impResp [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 0};

   always @(posedge aclk) cyc <= cyc + 1;

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] fitNarrow(input longint s);
`ifdef FIR_OUT_SAT_EN
      if (s > NMAX) return 32'h7FFF_FFFF;
      if (s < NMIN) return 32'h8000_0000;
`endif
      return s[31:0];
   endfunction

   task automatic modelReset();
      for (int k = 0; k < TAPS; k++) begin
         coefModel[k] = 0;
         histModel[k] = 0;
      end
   endtask

   task automatic modelAccept(input longint sample);
      longint s = 0;
      for (int k = TAPS - 1; k > 0; k--) histModel[k] = histModel[k-1];
      histModel[0] = sample;
      for (int k = 0; k < TAPS; k++) s += coefModel[k] * histModel[k];
      expWide   = s[39:0];
      expNarrow = fitNarrow(s);
   endtask

   task automatic writeCoef(input logic [2:0] addr, input logic [15:0] data);
      @(negedge aclk);
      checkVal("coef_wr_ready_idle", 64'(coefWrReady), 64'd1);
      coefWrEn = 1'b1; coefWrAddr = addr; coefWrData = data;
      @(posedge aclk); #1;
      coefWrEn = 1'b0;
      coefModel[addr] = longint'($signed(data));
   endtask

   task automatic applyStimulus(input logic [15:0] sample, input bit withWr,
                                input logic [2:0] wAddr, input logic [15:0] wData);
      int waited = 0;
      @(negedge aclk);
      while (!sTready && waited < 40) begin
         @(negedge aclk);
         waited++;
      end
      if (!sTready) begin
         checkVal("accept_timeout", 64'(sTready), 64'd1);
         return;
      end
      sTvalid = 1'b1;
      sTdata  = sample;
      if (withWr) begin
         coefWrEn = 1'b1; coefWrAddr = wAddr; coefWrData = wData;
         coefModel[wAddr] = longint'($signed(wData));
      end
      @(posedge aclk); #1;
      sTvalid  = 1'b0;
      coefWrEn = 1'b0;
      sTdata   = 16'($urandom);
      prevAcceptCyc = acceptCyc;
      acceptCyc     = cyc;
      modelAccept(longint'($signed(sample)));
   endtask

   task automatic checkOutput(input string tag, input int holdCycles);
      int waited = 0;
      @(negedge aclk);
      while (!mTvalid && waited < 40) begin
         checkVal({tag, "_s_tready_busy"}, 64'(sTready), 64'd0);
         @(negedge aclk);
         waited++;
      end
      checkVal({tag, "_valid"}, 64'(mTvalid), 64'd1);
      checkVal({tag, "_valid_narrow"}, 64'(mTvalidN), 64'd1);
      checkVal({tag, "_latency"}, 64'(cyc + 1 - acceptCyc), 64'(TAPS + 1));
      checkVal({tag, "_data"}, 64'(mTdata), 64'(expWide));
      checkVal({tag, "_data_narrow"}, 64'(mTdataN), 64'(expNarrow));
      lastOut  = mTdata;
      lastOutN = mTdataN;
      for (int i = 0; i < holdCycles; i++) begin
         @(negedge aclk);
         checkVal({tag, "_hold_valid"}, 64'(mTvalid), 64'd1);
         checkVal({tag, "_hold_data"}, 64'(mTdata), 64'(expWide));
         checkVal({tag, "_hold_s_tready"}, 64'(sTready), 64'd0);
      end
      mTready = 1'b1;
      @(posedge aclk); #1;
      handshakeCyc = cyc;
      mTready = 1'b0;
      checkVal({tag, "_valid_drop"}, 64'(mTvalid), 64'd0);
   endtask

   initial begin
      areset = 1'b1; sTvalid = 1'b0; sTdata = '0; mTready = 1'b0;
      coefWrEn = 1'b0; coefWrAddr = '0; coefWrData = '0;
      modelReset();
      repeat (3) @(posedge aclk);
      #1;
      checkVal("rst_s_tready", 64'(sTready), 64'd0);
      checkVal("rst_s_tready_narrow", 64'(sTreadyN), 64'd0);
      checkVal("rst_coef_ready", 64'(coefWrReady), 64'd0);
      checkVal("rst_coef_ready_narrow", 64'(coefWrReadyN), 64'd0);
      checkVal("rst_m_tvalid", 64'(mTvalid), 64'd0);
      checkVal("rst_m_tdata", 64'(mTdata), 64'd0);
      @(negedge aclk);
      areset = 1'b0;
      @(posedge aclk); #1;
      checkVal("idle_s_tready", 64'(sTready), 64'd1);
      checkVal("idle_coef_ready", 64'(coefWrReady), 64'd1);

      $display("[TB] impulse response");
      for (int k = 0; k < TAPS; k++) writeCoef(3'(k), 16'(k + 1));
      for (int n = 0; n < 9; n++) begin
         applyStimulus((n == 0) ? 16'd1 : 16'd0, 1'b0, 3'd0, 16'd0);
         if (n > 0) checkVal("imp_period", 64'(acceptCyc - prevAcceptCyc), 64'(TAPS + 2));
         checkOutput("imp", 0);
         checkVal("imp_const", 64'(lastOut), 64'(impResp[n]));
      end

      $display("[TB] coefficient reload");
      applyStimulus(16'd6, 1'b0, 3'd0, 16'd0); checkOutput("reload_pre", 0);
      applyStimulus(16'd0, 1'b0, 3'd0, 16'd0); checkOutput("reload_pre", 0);
      applyStimulus(16'd0, 1'b0, 3'd0, 16'd0); checkOutput("reload_pre", 0);
      applyStimulus(16'd0, 1'b0, 3'd0, 16'd0);
      @(negedge aclk);
      checkVal("mac_coef_ready", 64'(coefWrReady), 64'd0);
      coefWrEn = 1'b1; coefWrAddr = 3'd3; coefWrData = 16'hFFFE;
      @(posedge aclk); #1;
      coefWrEn = 1'b0;
      checkOutput("reload_old", 0);
      checkVal("reload_old_const", 64'(lastOut), 64'd24);
      applyStimulus(16'd5, 1'b0, 3'd0, 16'd0); checkOutput("reload_mid", 0);
      applyStimulus(16'd0, 1'b0, 3'd0, 16'd0); checkOutput("reload_mid", 0);
      applyStimulus(16'd0, 1'b0, 3'd0, 16'd0); checkOutput("reload_mid", 0);
      applyStimulus(16'd0, 1'b1, 3'd3, 16'hFFFE);
      checkOutput("reload_new", 0);
      checkVal("reload_new_const", 64'(lastOut), 64'd38);

      $display("[TB] backpressure");
      applyStimulus(16'd3, 1'b0, 3'd0, 16'd0);
      checkOutput("bp", 20);
      applyStimulus(16'd0, 1'b0, 3'd0, 16'd0);
      checkVal("bp_next_accept", 64'(acceptCyc - handshakeCyc), 64'd1);
      checkOutput("bp_after", 0);

      $display("[TB] overflow");
      for (int k = 0; k < TAPS; k++) writeCoef(3'(k), 16'sd32767);
      for (int n = 0; n < TAPS; n++) begin
         applyStimulus(16'sd32767, 1'b0, 3'd0, 16'd0);
         checkOutput("ovf_pos", 0);
      end
      checkVal("ovf_pos_wide", 64'(lastOut), 64'h01_FFF8_0008);
`ifdef FIR_OUT_SAT_EN
      checkVal("ovf_pos_narrow", 64'(lastOutN), 64'h7FFF_FFFF);
`else
      checkVal("ovf_pos_narrow", 64'(lastOutN), 64'hFFF8_0008);
`endif
      for (int n = 0; n < TAPS; n++) begin
         applyStimulus(16'h8000, 1'b0, 3'd0, 16'd0);
         checkOutput("ovf_neg", 0);
      end
      checkVal("ovf_neg_wide", 64'(lastOut), 64'hFE_0004_0000);
`ifdef FIR_OUT_SAT_EN
      checkVal("ovf_neg_narrow", 64'(lastOutN), 64'h8000_0000);
`else
      checkVal("ovf_neg_narrow", 64'(lastOutN), 64'h0004_0000);
`endif

      $display("[TB] reset mid-MAC");
      applyStimulus(16'd9, 1'b0, 3'd0, 16'd0);
      repeat (3) @(negedge aclk);
      areset = 1'b1;
      @(posedge aclk); #1;
      checkVal("rst_mid_valid", 64'(mTvalid), 64'd0);
      checkVal("rst_mid_data", 64'(mTdata), 64'd0);
      checkVal("rst_mid_s_tready", 64'(sTready), 64'd0);
      checkVal("rst_mid_coef_ready", 64'(coefWrReady), 64'd0);
      @(negedge aclk);
      areset = 1'b0;
      modelReset();
      for (int i = 0; i < TAPS + 4; i++) begin
         @(negedge aclk);
         checkVal("rst_no_output", 64'(mTvalid), 64'd0);
      end
      for (int k = 0; k < TAPS; k++) writeCoef(3'(k), 16'(k + 1));
      for (int n = 0; n < TAPS; n++) begin
         applyStimulus((n == 0) ? 16'd1 : 16'd0, 1'b0, 3'd0, 16'd0);
         checkOutput("rst_imp", 0);
         checkVal("rst_imp_const", 64'(lastOut), 64'(impResp[n]));
      end

      $display("[TB] random traffic");
      for (int k = 0; k < TAPS; k++) writeCoef(3'(k), 16'($urandom));
      for (int n = 0; n < 12; n++) begin
         if ($urandom_range(0, 2) == 0)
            applyStimulus(16'($urandom), 1'b1, 3'($urandom_range(0, TAPS - 1)), 16'($urandom));
         else
            applyStimulus(16'($urandom), 1'b0, 3'd0, 16'd0);
         checkOutput("rand", int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog observed=still_running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
